// File: rtl/block_mean_accumulator_if.sv
// Stream bundle for block_mean_accumulator: sample input channel
// (in_valid/in_ready/in_data/in_last) and closed-block output slot
// (out_valid/out_ready/out_sum/out_cnt/out_ovf).
// The slave modport is the accumulator's view; master is the feeder/consumer side.
interface block_mean_accumulator_if #(
    parameter int DATA_WIDTH = 8,
    parameter int SUM_WIDTH  = 16,
    parameter int CNT_WIDTH  = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [SUM_WIDTH-1:0]  out_sum;
    logic [CNT_WIDTH-1:0]  out_cnt;
    logic                  out_ovf;

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_cnt,
        output out_ovf
    );

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_cnt,
        input  out_ovf
    );
endinterface

// File: rtl/block_mean_accumulator.sv
// block_mean_accumulator
// Sums a stream of unsigned samples per block and counts them. When a block
// closes (in_last, or the counter reaching its maximum) the totals move into a
// single registered output slot that feeds a combinational divider (sum is the
// dividend, count the divisor). The slot passes through when drained, so a new
// block can close on the same edge the previous one is taken.
// Sum arithmetic saturates; out_ovf flags any saturation within the block.
// Optional build macro ACC_ROUND_EN: adds count/2 to the closing sum so that
// the divider's floor gives a round-half-up mean.
module block_mean_accumulator #(
    parameter int DATA_WIDTH = 8,
    parameter int SUM_WIDTH  = 16,
    parameter int CNT_WIDTH  = 8
) (
    input logic                    clk,
    input logic                    rst,
    block_mean_accumulator_if.slave bus
);

    localparam logic [0:0]           ST_IDLE  = 1'b0;
    localparam logic [0:0]           ST_ACCUM = 1'b1;
    localparam logic [SUM_WIDTH-1:0] SUM_MAX  = {SUM_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    // Saturating unsigned add; bit [SUM_WIDTH] reports that a carry occurred.
    function automatic logic [SUM_WIDTH:0] sat_add(
        input logic [SUM_WIDTH-1:0] a,
        input logic [SUM_WIDTH-1:0] b
    );
        logic [SUM_WIDTH:0] wide;
        wide = {1'b0, a} + {1'b0, b};
        if (wide[SUM_WIDTH]) begin
            sat_add = {1'b1, SUM_MAX};
        end else begin
            sat_add = wide;
        end
    endfunction

    // Registered state
    logic [0:0]           state_q,     state_d;
    logic [SUM_WIDTH-1:0] acc_sum_q,   acc_sum_d;
    logic [CNT_WIDTH-1:0] acc_cnt_q,   acc_cnt_d;
    logic                 acc_ovf_q,   acc_ovf_d;
    logic                 out_valid_q, out_valid_d;
    logic [SUM_WIDTH-1:0] out_sum_q,   out_sum_d;
    logic [CNT_WIDTH-1:0] out_cnt_q,   out_cnt_d;
    logic                 out_ovf_q,   out_ovf_d;

    // Datapath signals
    logic                 in_ready_s;
    logic                 accept_s;
    logic                 close_s;
    logic [SUM_WIDTH-1:0] data_ext_s;
    logic [SUM_WIDTH-1:0] base_sum_s;
    logic [CNT_WIDTH-1:0] base_cnt_s;
    logic                 base_ovf_s;
    logic [SUM_WIDTH-1:0] new_sum_s;
    logic                 add_ovf_s;
    logic [CNT_WIDTH-1:0] new_cnt_s;
    logic                 new_ovf_s;
    logic [SUM_WIDTH-1:0] fin_sum_s;
    logic                 fin_ovf_s;
`ifdef ACC_ROUND_EN
    logic                 rnd_ovf_s;
`endif

    // Single output slot: a sample may enter whenever the slot is empty or
    // is being drained this cycle.
    assign in_ready_s = !out_valid_q || bus.out_ready;
    assign accept_s   = bus.in_valid && in_ready_s;
    assign data_ext_s = SUM_WIDTH'(bus.in_data);

    // Running totals including the sample offered this cycle; an idle FSM
    // starts from zero so the first sample of a block is loaded, not added.
    always_comb begin
        base_sum_s = '0;
        base_cnt_s = '0;
        base_ovf_s = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                base_sum_s = acc_sum_q;
                base_cnt_s = acc_cnt_q;
                base_ovf_s = acc_ovf_q;
            end
            ST_IDLE: begin
                base_sum_s = '0;
                base_cnt_s = '0;
                base_ovf_s = 1'b0;
            end
            default: begin
                base_sum_s = '0;
                base_cnt_s = '0;
                base_ovf_s = 1'b0;
            end
        endcase
        {add_ovf_s, new_sum_s} = sat_add(base_sum_s, data_ext_s);
        new_cnt_s = base_cnt_s + CNT_WIDTH'(1);
        new_ovf_s = base_ovf_s | add_ovf_s;
    end

    // Block closes on a qualified in_last or when the counter would reach
    // its maximum, which keeps the count from ever wrapping to zero.
    assign close_s = accept_s && (bus.in_last || (new_cnt_s == CNT_MAX));

`ifdef ACC_ROUND_EN
    // Closing sum biased by count/2 so a floor divide rounds half up.
    always_comb begin
        {rnd_ovf_s, fin_sum_s} = sat_add(new_sum_s, SUM_WIDTH'(new_cnt_s >> 1));
        fin_ovf_s = new_ovf_s | rnd_ovf_s;
    end
`else
    // Closing sum passed through unchanged (divider yields truncated mean).
    always_comb begin
        fin_sum_s = new_sum_s;
        fin_ovf_s = new_ovf_s;
    end
`endif

    // Accumulator FSM: open a block on first accept, add while open, clear on close.
    always_comb begin
        state_d   = state_q;
        acc_sum_d = acc_sum_q;
        acc_cnt_d = acc_cnt_q;
        acc_ovf_d = acc_ovf_q;
        if (close_s) begin
            state_d   = ST_IDLE;
            acc_sum_d = '0;
            acc_cnt_d = '0;
            acc_ovf_d = 1'b0;
        end else if (accept_s) begin
            state_d   = ST_ACCUM;
            acc_sum_d = new_sum_s;
            acc_cnt_d = new_cnt_s;
            acc_ovf_d = new_ovf_s;
        end else begin
            state_d   = state_q;
            acc_sum_d = acc_sum_q;
            acc_cnt_d = acc_cnt_q;
            acc_ovf_d = acc_ovf_q;
        end
    end

    // Output slot: load on close (even while draining, so no bubble), clear
    // valid on drain, otherwise hold the presented block stable.
    always_comb begin
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_cnt_d   = out_cnt_q;
        out_ovf_d   = out_ovf_q;
        if (close_s) begin
            out_valid_d = 1'b1;
            out_sum_d   = fin_sum_s;
            out_cnt_d   = new_cnt_s;
            out_ovf_d   = fin_ovf_s;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; reset discards any open block and any pending output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_sum_q   <= '0;
            acc_cnt_q   <= '0;
            acc_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_cnt_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_sum_q   <= acc_sum_d;
            acc_cnt_q   <= acc_cnt_d;
            acc_ovf_q   <= acc_ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_cnt_q   <= out_cnt_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_cnt   = out_cnt_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_block_mean_accumulator.sv
// Testbench for block_mean_accumulator. A reference model follows every
// accepted sample and pushes the expected block on close; each drain pops
// and compares. A second instance with a 12-bit sum sees identical stimulus
// and is checked directly for saturation.
module tb_block_mean_accumulator;

    typedef struct {
        logic [15:0] sum;
        logic [7:0]  cnt;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst;

    block_mean_accumulator_if #(.DATA_WIDTH(8), .SUM_WIDTH(16), .CNT_WIDTH(8)) bus ();
    block_mean_accumulator_if #(.DATA_WIDTH(8), .SUM_WIDTH(12), .CNT_WIDTH(8)) bus12 ();

    block_mean_accumulator #(.DATA_WIDTH(8), .SUM_WIDTH(16), .CNT_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    block_mean_accumulator #(.DATA_WIDTH(8), .SUM_WIDTH(12), .CNT_WIDTH(8)) dut12 (
        .clk (clk),
        .rst (rst),
        .bus (bus12)
    );

    assign bus12.in_valid  = bus.in_valid;
    assign bus12.in_data   = bus.in_data;
    assign bus12.in_last   = bus.in_last;
    assign bus12.out_ready = bus.out_ready;

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_sum = 0;
    int   m_cnt = 0;
    bit   m_ovf = 1'b0;
    bit   last_accept = 1'b0;

    task automatic drive(input logic v, input logic [7:0] d, input logic l);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_last  = l;
    endtask

    // One clock: observe the handshakes settled before the edge, score a
    // drain against the queue, update the model on acceptance, return at negedge.
    task automatic tick();
        exp_t e;
        bit   acc;
        bit   drn;
        int   es;
        bit   eo;
        #1;
        acc = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1);
        drn = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b1);
        if (drn) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got sum=%0d cnt=%0d, required no output", bus.out_sum, bus.out_cnt);
            end else begin
                e = sb.pop_front();
                if (bus.out_sum !== e.sum || bus.out_cnt !== e.cnt || bus.out_ovf !== e.ovf) begin
                    n_err++;
                    $display("FAIL sb_block: got sum=%0d cnt=%0d ovf=%0b, required sum=%0d cnt=%0d ovf=%0b",
                             bus.out_sum, bus.out_cnt, bus.out_ovf, e.sum, e.cnt, e.ovf);
                end
            end
        end
        last_accept = acc;
        if (acc) begin
            m_sum = m_sum + int'(bus.in_data);
            if (m_sum > 65535) begin
                m_sum = 65535;
                m_ovf = 1'b1;
            end
            m_cnt = m_cnt + 1;
            if (bus.in_last === 1'b1 || m_cnt == 255) begin
                es = m_sum;
                eo = m_ovf;
`ifdef ACC_ROUND_EN
                es = es + m_cnt / 2;
                if (es > 65535) begin
                    es = 65535;
                    eo = 1'b1;
                end
`endif
                e.sum = 16'(es);
                e.cnt = 8'(m_cnt);
                e.ovf = eo;
                sb.push_back(e);
                m_sum = 0;
                m_cnt = 0;
                m_ovf = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        // outputs under the power-on reset
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.out_sum !== 16'd0 || bus.out_cnt !== 8'd0 ||
            bus.out_ovf !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_init: got v=%0b s=%0d c=%0d o=%0b rdy=%0b, required 0 0 0 0 1",
                     bus.out_valid, bus.out_sum, bus.out_cnt, bus.out_ovf, bus.in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        // closed block left pending, then reset
        bus.out_ready = 1'b0;
        drive(1'b1, 8'd40, 1'b0); tick();
        drive(1'b1, 8'd50, 1'b1); tick();
        drive(1'b0, 8'd0, 1'b0);  tick();
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_pending: got v=%0b rdy=%0b, required 1 0", bus.out_valid, bus.in_ready);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.out_sum !== 16'd0 || bus.out_cnt !== 8'd0 ||
            bus.out_ovf !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_async: got v=%0b s=%0d c=%0d o=%0b rdy=%0b, required 0 0 0 0 1",
                     bus.out_valid, bus.out_sum, bus.out_cnt, bus.out_ovf, bus.in_ready);
        end
        sb.delete();
        m_sum = 0; m_cnt = 0; m_ovf = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        // partial block, then reset mid-block
        bus.out_ready = 1'b1;
        drive(1'b1, 8'd33, 1'b0); tick();
        drive(1'b1, 8'd44, 1'b0);
        rst = 1'b1;
        #1;
        sb.delete();
        m_sum = 0; m_cnt = 0; m_ovf = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 8'd0, 1'b0);
        @(negedge clk);
        // fresh block after release: exactly the one new sample
        drive(1'b1, 8'd7, 1'b1); tick();
        drive(1'b0, 8'd0, 1'b0);
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_sum !== 16'd7 || bus.out_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL reset_fresh: got v=%0b s=%0d c=%0d, required 1 7 1",
                     bus.out_valid, bus.out_sum, bus.out_cnt);
        end
        tick();
    endtask

    task automatic test_basic_mean();
        bus.out_ready = 1'b1;
        drive(1'b1, 8'd25, 1'b0); tick();
        drive(1'b1, 8'd25, 1'b0); tick();
        drive(1'b0, 8'd99, 1'b1); tick();
        drive(1'b1, 8'd25, 1'b0); tick();
        drive(1'b1, 8'd25, 1'b1); tick();
        drive(1'b0, 8'd0, 1'b0);
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_sum !== 16'd100 || bus.out_cnt !== 8'd4 || bus.out_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL basic_mean: got v=%0b s=%0d c=%0d o=%0b, required 1 100 4 0",
                     bus.out_valid, bus.out_sum, bus.out_cnt, bus.out_ovf);
        end
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_one_cycle: got out_valid=%0b, required 0", bus.out_valid);
        end
    endtask

    task automatic test_two_sample();
        logic [15:0] want;
`ifdef ACC_ROUND_EN
        want = 16'd22;
`else
        want = 16'd21;
`endif
        bus.out_ready = 1'b1;
        drive(1'b1, 8'd10, 1'b0); tick();
        drive(1'b1, 8'd11, 1'b1); tick();
        drive(1'b0, 8'd0, 1'b0);
        n_cmp++;
        if (bus.out_sum !== want || bus.out_cnt !== 8'd2) begin
            n_err++;
            $display("FAIL two_sample: got s=%0d c=%0d, required s=%0d c=2", bus.out_sum, bus.out_cnt, want);
        end
        tick();
    endtask

    task automatic test_single_sample();
        logic [15:0] q;
        bus.out_ready = 1'b1;
        drive(1'b1, 8'd128, 1'b1); tick();
        drive(1'b0, 8'd0, 1'b0);
        q = (bus.out_cnt != 8'd0) ? (bus.out_sum / 16'(bus.out_cnt)) : 16'hFFFF;
        n_cmp++;
        if (bus.out_cnt !== 8'd1 || q !== 16'd128) begin
            n_err++;
            $display("FAIL single_sample: got c=%0d q=%0d, required c=1 q=128", bus.out_cnt, q);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [15:0] s_snap;
        logic [7:0]  c_snap;
        bus.out_ready = 1'b0;
        drive(1'b1, 8'd3, 1'b0); tick();
        drive(1'b1, 8'd4, 1'b1); tick();
        s_snap = bus.out_sum;
        c_snap = bus.out_cnt;
        drive(1'b1, 8'd9, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (bus.in_ready !== 1'b0 || last_accept !== 1'b0 || bus.out_valid !== 1'b1 ||
                bus.out_sum !== s_snap || bus.out_cnt !== c_snap || c_snap !== 8'd2) begin
                n_err++;
                $display("FAIL backpressure_hold: got rdy=%0b acc=%0b v=%0b s=%0d c=%0d, required 0 0 1 %0d 2",
                         bus.in_ready, last_accept, bus.out_valid, bus.out_sum, bus.out_cnt, s_snap);
            end
        end
        bus.out_ready = 1'b1;
        tick();
        n_cmp++;
        if (last_accept !== 1'b1) begin
            n_err++;
            $display("FAIL backpressure_release: got accepted=%0b, required 1", last_accept);
        end
        drive(1'b1, 8'd1, 1'b1); tick();
        drive(1'b0, 8'd0, 1'b0); tick();
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        drive(1'b1, 8'd5, 1'b1); tick();
        drive(1'b1, 8'd6, 1'b1); tick();
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_sum !== 16'd6) begin
            n_err++;
            $display("FAIL b2b_reload: got v=%0b s=%0d, required 1 6", bus.out_valid, bus.out_sum);
        end
        drive(1'b1, 8'd7, 1'b1); tick();
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_sum !== 16'd7 || bus.out_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL b2b_reload2: got v=%0b s=%0d c=%0d, required 1 7 1", bus.out_valid, bus.out_sum, bus.out_cnt);
        end
        drive(1'b0, 8'd0, 1'b0); tick();
    endtask

    task automatic test_forced_close();
        logic [15:0] want16;
`ifdef ACC_ROUND_EN
        want16 = 16'd65152;
`else
        want16 = 16'd65025;
`endif
        bus.out_ready = 1'b1;
        for (int i = 0; i < 255; i++) begin
            drive(1'b1, 8'd255, 1'b0);
            tick();
        end
        drive(1'b0, 8'd0, 1'b0);
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_cnt !== 8'd255 || bus.out_sum !== want16 || bus.out_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL forced_close16: got v=%0b s=%0d c=%0d o=%0b, required 1 %0d 255 0",
                     bus.out_valid, bus.out_sum, bus.out_cnt, bus.out_ovf, want16);
        end
        n_cmp++;
        if (bus12.out_valid !== 1'b1 || bus12.out_cnt !== 8'd255 || bus12.out_sum !== 12'd4095 || bus12.out_ovf !== 1'b1) begin
            n_err++;
            $display("FAIL forced_close12: got v=%0b s=%0d c=%0d o=%0b, required 1 4095 255 1",
                     bus12.out_valid, bus12.out_sum, bus12.out_cnt, bus12.out_ovf);
        end
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus12.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL forced_drain: got v16=%0b v12=%0b, required 0 0", bus.out_valid, bus12.out_valid);
        end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        bus.out_ready = 1'b0;
        drive(1'b0, 8'd0, 1'b0);
        repeat (2) @(negedge clk);
        test_reset();
        test_basic_mean();
        test_two_sample();
        test_single_sample();
        test_backpressure();
        test_back_to_back();
        test_forced_close();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: got %0d undelivered blocks, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
